// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the VGA timing generator slice.
//   mode_e      : output pattern selector (external, bars, grid, black)
//   DEF_*       : standard 640x480 timing constants
//   vgaTotal()  : total pixels per line or lines per frame from the four
//                 timing segments
//   ctrWidth()  : counter width able to hold 0..n-1 (never below one bit)
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_EXT   = 2'b00,
    MODE_BARS  = 2'b01,
    MODE_GRID  = 2'b10,
    MODE_BLACK = 2'b11
  } mode_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // One line (or one frame) is the active area followed by the front
  // porch, the sync pulse and the back porch.
  function automatic int vgaTotal(input int active, input int fp,
                                  input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Width for a counter that runs 0..n-1; a one-value counter still
  // gets a single bit so every vector keeps a legal range.
  function automatic int ctrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_pattern.sv
// vga_pattern
// Purely combinational colour source for the requested pixel.
//   mode_i                 : selected pattern
//   x_i, y_i               : requested column / line (0 outside active area)
//   pixR_i, pixG_i, pixB_i : external pixel data used in MODE_EXT
//   r_o, g_o, b_o          : selected colour
module vga_pattern
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int XW       = 10,
  parameter int YW       = 9,
  parameter int COLOR_W  = 4
) (
  input  mode_e              mode_i,
  input  logic [XW-1:0]      x_i,
  input  logic [YW-1:0]      y_i,
  input  logic [COLOR_W-1:0] pixR_i,
  input  logic [COLOR_W-1:0] pixG_i,
  input  logic [COLOR_W-1:0] pixB_i,
  output logic [COLOR_W-1:0] r_o,
  output logic [COLOR_W-1:0] g_o,
  output logic [COLOR_W-1:0] b_o
);

  logic [31:0] xWide;
  logic [31:0] yWide;
  logic [2:0]  barIdx;
  logic [2:0]  barBits;
  logic        onGrid;

  // Eight equal-width bars across the active area; inverting the index
  // makes bar 0 white and bar 7 black, with bit 2 on red and bit 0 on blue.
  // Grid lines fall on every 32nd column and line, widened to 32 bits so
  // narrow coordinate buses still work.
  assign xWide   = 32'(x_i);
  assign yWide   = 32'(y_i);
  assign barIdx  = 3'((xWide * 32'd8) / 32'(H_ACTIVE));
  assign barBits = ~barIdx;
  assign onGrid  = ((xWide & 32'd31) == 32'd0) || ((yWide & 32'd31) == 32'd0);

  // Pick the colour for the current mode, black unless a pattern says
  // otherwise.
  always_comb begin
    r_o = '0;
    g_o = '0;
    b_o = '0;
    case (mode_i)
      MODE_EXT: begin
        r_o = pixR_i;
        g_o = pixG_i;
        b_o = pixB_i;
      end
      MODE_BARS: begin
        r_o = {COLOR_W{barBits[2]}};
        g_o = {COLOR_W{barBits[1]}};
        b_o = {COLOR_W{barBits[0]}};
      end
      MODE_GRID: begin
        if (onGrid) begin
          r_o = '1;
          g_o = '1;
          b_o = '1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// VGA raster timing with a pixel-request interface and registered outputs.
//   CLK1_50, RST           : clock, synchronous active-high reset
//   EN                     : run enable; when low the raster freezes and
//                            outputs blank with syncs inactive
//   MODE                   : 00 external, 01 bars, 10 grid, 11 black
//   REQ_X, REQ_Y, REQ_VALID: pixel currently requested (combinational)
//   PIX_R/G/B              : external pixel for the current request
//   VGA_R/G/B, VGA_HS/VS   : registered colour and syncs, one tick late
//   FRAME_START            : one-cycle pulse at the h=0,v=0 pixel tick
//   FRAME_CNT              : completed frames, wrapping at 16 bits
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter int   CLK_DIV  = 2,
  parameter int   COLOR_W  = 4,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic                        CLK1_50,
  input  logic                        RST,
  input  logic                        EN,
  input  logic [1:0]                  MODE,
  output logic [$clog2(H_ACTIVE)-1:0] REQ_X,
  output logic [$clog2(V_ACTIVE)-1:0] REQ_Y,
  output logic                        REQ_VALID,
  input  logic [COLOR_W-1:0]          PIX_R,
  input  logic [COLOR_W-1:0]          PIX_G,
  input  logic [COLOR_W-1:0]          PIX_B,
  output logic [COLOR_W-1:0]          VGA_R,
  output logic [COLOR_W-1:0]          VGA_G,
  output logic [COLOR_W-1:0]          VGA_B,
  output logic                        VGA_HS,
  output logic                        VGA_VS,
  output logic                        FRAME_START,
  output logic [15:0]                 FRAME_CNT
);

  localparam int H_TOTAL = vgaTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vgaTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = $clog2(V_ACTIVE);
  localparam int HW      = ctrWidth(H_TOTAL);
  localparam int VW      = ctrWidth(V_TOTAL);
  localparam int DW      = ctrWidth(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0]      div_q, div_d;
  logic [HW-1:0]      h_q, h_d;
  logic [VW-1:0]      v_q, v_d;
  logic [15:0]        frameCnt_q, frameCnt_d;
  mode_e              mode_q, mode_d, modeSel;
  logic [COLOR_W-1:0] vgaR_q, vgaR_d, vgaG_q, vgaG_d, vgaB_q, vgaB_d;
  logic               hs_q, hs_d, vs_q, vs_d;
  logic [COLOR_W-1:0] patR, patG, patB;
  logic               ce, hLast, vLast, atOrigin, reqValid, hsActive, vsActive;

  // Pixel tick and raster decodes. Reset suppresses the tick so nothing
  // pulses while RST is held, even with CLK_DIV=1. The pixel at h=0,v=0
  // already uses the incoming MODE, so a new mode covers its whole frame.
  assign ce       = EN && !RST && (div_q == DIV_LAST);
  assign hLast    = (h_q == H_LAST);
  assign vLast    = (v_q == V_LAST);
  assign atOrigin = (h_q == '0) && (v_q == '0);
  assign reqValid = (h_q <= H_ACT_LAST) && (v_q <= V_ACT_LAST);
  assign hsActive = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
  assign vsActive = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
  assign modeSel  = atOrigin ? mode_e'(MODE) : mode_q;

  assign REQ_VALID = reqValid;
  assign REQ_X     = reqValid ? h_q[XW-1:0] : '0;
  assign REQ_Y     = reqValid ? v_q[YW-1:0] : '0;

  vga_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW),
    .YW       (YW),
    .COLOR_W  (COLOR_W)
  ) u_pattern (
    .mode_i (modeSel),
    .x_i    (REQ_X),
    .y_i    (REQ_Y),
    .pixR_i (PIX_R),
    .pixG_i (PIX_G),
    .pixB_i (PIX_B),
    .r_o    (patR),
    .g_o    (patG),
    .b_o    (patB)
  );

  // Next-state logic. With EN low everything holds except the outputs,
  // which blank with syncs parked inactive. With EN high the divider
  // free-runs and each tick steps the raster and loads colour and syncs
  // for the same h,v so they stay aligned one tick behind the request.
  always_comb begin
    div_d      = div_q;
    h_d        = h_q;
    v_d        = v_q;
    frameCnt_d = frameCnt_q;
    mode_d     = mode_q;
    vgaR_d     = vgaR_q;
    vgaG_d     = vgaG_q;
    vgaB_d     = vgaB_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    if (!EN) begin
      vgaR_d = '0;
      vgaG_d = '0;
      vgaB_d = '0;
      hs_d   = ~SYNC_POL;
      vs_d   = ~SYNC_POL;
    end else begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      if (ce) begin
        h_d = hLast ? '0 : h_q + 1'b1;
        if (hLast) begin
          v_d = vLast ? '0 : v_q + 1'b1;
          if (vLast) begin
            frameCnt_d = frameCnt_q + 16'd1;
          end
        end
        if (atOrigin) begin
          mode_d = modeSel;
        end
        vgaR_d = reqValid ? patR : '0;
        vgaG_d = reqValid ? patG : '0;
        vgaB_d = reqValid ? patB : '0;
        hs_d   = hsActive ? SYNC_POL : ~SYNC_POL;
        vs_d   = vsActive ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  // State and output registers; reset wins over EN and restarts the
  // raster at the top-left with outputs blank.
  always_ff @(posedge CLK1_50) begin
    if (RST) begin
      div_q      <= '0;
      h_q        <= '0;
      v_q        <= '0;
      frameCnt_q <= '0;
      mode_q     <= MODE_EXT;
      vgaR_q     <= '0;
      vgaG_q     <= '0;
      vgaB_q     <= '0;
      hs_q       <= ~SYNC_POL;
      vs_q       <= ~SYNC_POL;
    end else begin
      div_q      <= div_d;
      h_q        <= h_d;
      v_q        <= v_d;
      frameCnt_q <= frameCnt_d;
      mode_q     <= mode_d;
      vgaR_q     <= vgaR_d;
      vgaG_q     <= vgaG_d;
      vgaB_q     <= vgaB_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
    end
  end

  assign VGA_R       = vgaR_q;
  assign VGA_G       = vgaG_q;
  assign VGA_B       = vgaB_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign FRAME_CNT   = frameCnt_q;
  assign FRAME_START = ce && atOrigin;

endmodule
